mem_port_sequencer: RTL and testbench

//  Memory-side sequencer directly upstream of bus_control. Accepts one load/store request at a time.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/wait_timer.sv | 29 ++
 rtl/mem_port_sequencer.sv | 144 ++++++++++++++
 tb/tb_mem_port_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port sequencer: FSM state encodings
// and byte-enable patterns.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER0 = 3'd1,
        ST_XFER1 = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    // Byte enables for the first (or only) transfer of a request. An odd
    // address always starts on the high lane; a split word finishes on the
    // low lane of the next address.
    function automatic logic [1:0] be_first(input logic word, input logic odd);
        if (odd)
            return BE_HI;
        else if (word)
            return BE_BOTH;
        else
            return BE_LO;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Stall counter for a single memory transfer. Counts cycles while enabled and
// flags when the count has reached TIMEOUT; holds there until cleared.
module wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk_no_inhibit,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic hit
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Count stalled cycles; clear wins over counting, and the count never
    // advances past the terminal value.
    always_ff @(posedge clk_no_inhibit) begin
        if (reset || clear)
            cnt <= '0;
        else if (count_en && !hit)
            cnt <= cnt + CNT_W'(1);
    end

    assign hit = (cnt == TC);

endmodule

// File: rtl/mem_port_sequencer.sv
// Memory-side sequencer feeding bus_control. Accepts one load/store at a time,
// splits odd-address word accesses into two byte transfers and aborts a
// transfer that stalls for too long.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ready for a request; latches request fields on req_valid
//  ST_XFER0 | first (or only) transfer at addr_q, strobe held to mem_ready
//  ST_XFER1 | second half of a split word at addr_q+1, low lane
//  ST_DONE  | one-cycle done pulse
//  ST_ERR   | one-cycle bus_error pulse after a timeout
module mem_port_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk_no_inhibit,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              req_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    input  logic              mem_ready,
    output logic              odd_address,
    output logic              word,
    output logic              second_half,
    output logic              done,
    output logic              bus_error
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              word_q;
    logic              in_xfer;
    logic              split;
    logic              timer_hit;

    assign in_xfer = (state_q == ST_XFER0) || (state_q == ST_XFER1);
    assign split   = word_q && addr_q[0];

    // The counter restarts whenever a transfer completes, so the XFER0->XFER1
    // hand-off gives the second half its own full timeout budget.
    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk_no_inhibit (clk_no_inhibit),
        .reset          (reset),
        .clear          (!in_xfer || mem_ready),
        .count_en       (in_xfer && !mem_ready),
        .hit            (timer_hit)
    );

    // State register and request capture; fields are sampled only on accept.
    always_ff @(posedge clk_no_inhibit) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                word_q  <= req_word;
            end
        end
    end

    // Next-state logic; mem_ready takes priority over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_XFER0;
            ST_XFER0: begin
                if (mem_ready)
                    state_d = split ? ST_XFER1 : ST_DONE;
                else if (timer_hit)
                    state_d = ST_ERR;
            end
            ST_XFER1: begin
                if (mem_ready)
                    state_d = ST_DONE;
                else if (timer_hit)
                    state_d = ST_ERR;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        req_ready   = 1'b0;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_be      = BE_NONE;
        odd_address = 1'b0;
        word        = 1'b0;
        second_half = 1'b0;
        done        = 1'b0;
        bus_error   = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_XFER0: begin
                mem_addr    = addr_q;
                mem_rd      = !write_q;
                mem_wr      = write_q;
                mem_be      = be_first(word_q, addr_q[0]);
                odd_address = addr_q[0];
                word        = word_q;
            end
            ST_XFER1: begin
                mem_addr    = addr_q + ADDR_W'(1);
                mem_rd      = !write_q;
                mem_wr      = write_q;
                mem_be      = BE_LO;
                odd_address = addr_q[0];
                word        = word_q;
                second_half = 1'b1;
            end
            ST_DONE: begin
                odd_address = addr_q[0];
                word        = word_q;
                done        = 1'b1;
            end
            ST_ERR:  bus_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: a table of per-cycle vectors plus
// hand-written sequences for the timeout corner cases.
module tb_mem_port_sequencer;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [15:0] addr;
        logic        wr;
        logic        wd;
        logic        rdy;
    } vin_t;

    typedef struct packed {
        logic        req_ready;
        logic [15:0] mem_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_be;
        logic        odd_address;
        logic        word;
        logic        second_half;
        logic        done;
        logic        bus_error;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    logic        clk_no_inhibit = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic        req_word = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic        odd_address;
    logic        word;
    logic        second_half;
    logic        done;
    logic        bus_error;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk_no_inhibit = ~clk_no_inhibit;

    mem_port_sequencer dut (
        .clk_no_inhibit (clk_no_inhibit),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_word       (req_word),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_be         (mem_be),
        .mem_ready      (mem_ready),
        .odd_address    (odd_address),
        .word           (word),
        .second_half    (second_half),
        .done           (done),
        .bus_error      (bus_error)
    );

    function automatic vin_t vi(logic rst, logic vld, logic [15:0] a, logic wr, logic wd, logic rdy);
        vin_t v;
        v.rst = rst; v.vld = vld; v.addr = a; v.wr = wr; v.wd = wd; v.rdy = rdy;
        return v;
    endfunction

    function automatic vout_t o_idle();
        vout_t o = '0;
        o.req_ready = 1'b1;
        return o;
    endfunction

    function automatic vout_t o_xfer(logic [15:0] a, logic wr, logic [1:0] be,
                                     logic odd, logic wd, logic sh);
        vout_t o = '0;
        o.mem_addr = a; o.mem_rd = !wr; o.mem_wr = wr; o.mem_be = be;
        o.odd_address = odd; o.word = wd; o.second_half = sh;
        return o;
    endfunction

    function automatic vout_t o_done(logic odd, logic wd);
        vout_t o = '0;
        o.done = 1'b1; o.odd_address = odd; o.word = wd;
        return o;
    endfunction

    function automatic vout_t o_err();
        vout_t o = '0;
        o.bus_error = 1'b1;
        return o;
    endfunction

    // Drive inputs at the falling edge, check the outputs of the current state
    // before the next rising edge consumes the inputs.
    task automatic apply(input string name, input vin_t i, input vout_t e);
        vout_t a;
        @(negedge clk_no_inhibit);
        reset = i.rst; req_valid = i.vld; req_addr = i.addr;
        req_write = i.wr; req_word = i.wd; mem_ready = i.rdy;
        #1;
        a = '{req_ready, mem_addr, mem_rd, mem_wr, mem_be, odd_address,
              word, second_half, done, bus_error};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s vec %0d: got rr=%b addr=%h rd=%b wr=%b be=%b odd=%b wd=%b sh=%b dn=%b err=%b, want rr=%b addr=%h rd=%b wr=%b be=%b odd=%b wd=%b sh=%b dn=%b err=%b",
                     name, n_vec, a.req_ready, a.mem_addr, a.mem_rd, a.mem_wr, a.mem_be,
                     a.odd_address, a.word, a.second_half, a.done, a.bus_error,
                     e.req_ready, e.mem_addr, e.mem_rd, e.mem_wr, e.mem_be,
                     e.odd_address, e.word, e.second_half, e.done, e.bus_error);
        end
    endtask

    task automatic add(input vin_t i, input vout_t o);
        vecs.push_back('{i, o});
    endtask

    initial begin
        // byte load @0x1234, ready on first strobe cycle
        add(vi(0,1,16'h1234,0,0,0), o_idle());
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'h1234,0,2'b01,0,0,0));
        add(vi(0,0,16'h0000,0,0,0), o_done(0,0));
        add(vi(0,0,16'h0000,0,0,0), o_idle());
        // aligned word store @0x2000, three wait cycles
        add(vi(0,1,16'h2000,1,1,0), o_idle());
        add(vi(0,1,16'h7777,0,0,0), o_xfer(16'h2000,1,2'b11,0,1,0));
        add(vi(0,0,16'h0000,0,0,0), o_xfer(16'h2000,1,2'b11,0,1,0));
        add(vi(0,0,16'h0000,0,0,0), o_xfer(16'h2000,1,2'b11,0,1,0));
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'h2000,1,2'b11,0,1,0));
        add(vi(0,0,16'h0000,0,0,0), o_done(0,1));
        add(vi(0,0,16'h0000,0,0,0), o_idle());
        // split word load @0x3001, busy-time request must be ignored
        add(vi(0,1,16'h3001,0,1,0), o_idle());
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'h3001,0,2'b10,1,1,0));
        add(vi(0,1,16'h5555,1,0,0), o_xfer(16'h3002,0,2'b01,1,1,1));
        add(vi(0,1,16'h5555,1,0,1), o_xfer(16'h3002,0,2'b01,1,1,1));
        add(vi(0,0,16'h0000,0,0,0), o_done(1,1));
        add(vi(0,0,16'h0000,0,0,0), o_idle());
        // split word store @0xFFFF wraps to 0x0000
        add(vi(0,1,16'hFFFF,1,1,0), o_idle());
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'hFFFF,1,2'b10,1,1,0));
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'h0000,1,2'b01,1,1,1));
        add(vi(0,0,16'h0000,0,0,0), o_done(1,1));
        add(vi(0,0,16'h0000,0,0,0), o_idle());
        // reset during XFER1
        add(vi(0,1,16'h4001,0,1,0), o_idle());
        add(vi(0,0,16'h0000,0,0,1), o_xfer(16'h4001,0,2'b10,1,1,0));
        add(vi(1,0,16'h0000,0,0,0), o_xfer(16'h4002,0,2'b01,1,1,1));
        add(vi(0,0,16'h0000,0,0,0), o_idle());
        add(vi(0,0,16'h0000,0,0,0), o_idle());

        repeat (2) @(negedge clk_no_inhibit);
        reset = 1'b1;
        @(negedge clk_no_inhibit);

        foreach (vecs[k]) apply("table", vecs[k].i, vecs[k].o);

        // stall: 16 XFER cycles with mem_ready low, then bus_error, no done
        apply("to_accept", vi(0,1,16'h0100,0,0,0), o_idle());
        for (int k = 0; k < 16; k++)
            apply("to_wait", vi(0,0,16'h0000,0,0,0), o_xfer(16'h0100,0,2'b01,0,0,0));
        apply("to_err", vi(0,0,16'h0000,0,0,0), o_err());
        apply("to_idle", vi(0,0,16'h0000,0,0,0), o_idle());

        // ready arrives exactly at the terminal count: success
        apply("tc_accept", vi(0,1,16'h0200,1,1,0), o_idle());
        for (int k = 0; k < 16; k++)
            apply("tc_wait", vi(0,0,16'h0000,0,0,(k == 15)), o_xfer(16'h0200,1,2'b11,0,1,0));
        apply("tc_done", vi(0,0,16'h0000,0,0,0), o_done(0,1));
        apply("tc_idle", vi(0,0,16'h0000,0,0,0), o_idle());

        // timeout in second half of a split word
        apply("t1_accept", vi(0,1,16'h0301,0,1,0), o_idle());
        apply("t1_x0", vi(0,0,16'h0000,0,0,1), o_xfer(16'h0301,0,2'b10,1,1,0));
        for (int k = 0; k < 16; k++)
            apply("t1_wait", vi(0,0,16'h0000,0,0,0), o_xfer(16'h0302,0,2'b01,1,1,1));
        apply("t1_err", vi(0,0,16'h0000,0,0,0), o_err());
        apply("t1_idle", vi(0,0,16'h0000,0,0,0), o_idle());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
